// File: rtl/mips_pkg.sv
// Shared constants and the ID/EX control bundle for the 16-bit MIPS-style pipeline.
package mips_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 3;
  localparam int OP_W    = 3;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic               regDst;
    logic               ALUSrc;
    logic               memtoReg;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               branch;
    logic [ALUOP_W-1:0] ALUOp;
    logic [OP_W-1:0]    opCode;
  } ctrl_t;

  // All-zero control: no register write, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/reg_id_ex_if.sv
// Decode-to-execute bus of the ID/EX register; flush exists only with REG_ID_EX_FLUSH_EN.
interface reg_id_ex_if;
  import mips_pkg::*;

  logic                   hit;
`ifdef REG_ID_EX_FLUSH_EN
  logic                   flush;
`endif
  logic [DATA_W-1:0]      nextinst;
  logic                   regDst;
  logic                   ALUSrc;
  logic                   memtoReg;
  logic                   regWrite;
  logic                   memRead;
  logic                   memWrite;
  logic                   branch;
  logic [ALUOP_W-1:0]     ALUOp;
  logic [OP_W-1:0]        opCode;
  logic [DATA_W-1:0]      readData1;
  logic [DATA_W-1:0]      readData2;
  logic [DATA_W-1:0]      signExtend;
  logic [REG_W-1:0]       rt;
  logic [REG_W-1:0]       rd;

  logic [DATA_W-1:0]      nextinstOut;
  logic                   regDstOut;
  logic                   ALUSrcOut;
  logic                   memtoRegOut;
  logic                   regWriteOut;
  logic                   memReadOut;
  logic                   memWriteOut;
  logic                   branchOut;
  logic [ALUOP_W-1:0]     ALUOpOut;
  logic [OP_W-1:0]        opCodeOut;
  logic [DATA_W-1:0]      readData1Out;
  logic [DATA_W-1:0]      readData2Out;
  logic [DATA_W-1:0]      signExtendOut;
  logic [REG_W-1:0]       rtOut;
  logic [REG_W-1:0]       rdOut;

  modport master (
    output hit,
`ifdef REG_ID_EX_FLUSH_EN
    output flush,
`endif
    output nextinst, regDst, ALUSrc, memtoReg, regWrite, memRead, memWrite, branch,
    output ALUOp, opCode, readData1, readData2, signExtend, rt, rd,
    input  nextinstOut, regDstOut, ALUSrcOut, memtoRegOut, regWriteOut, memReadOut,
    input  memWriteOut, branchOut, ALUOpOut, opCodeOut, readData1Out, readData2Out,
    input  signExtendOut, rtOut, rdOut
  );

  modport slave (
    input  hit,
`ifdef REG_ID_EX_FLUSH_EN
    input  flush,
`endif
    input  nextinst, regDst, ALUSrc, memtoReg, regWrite, memRead, memWrite, branch,
    input  ALUOp, opCode, readData1, readData2, signExtend, rt, rd,
    output nextinstOut, regDstOut, ALUSrcOut, memtoRegOut, regWriteOut, memReadOut,
    output memWriteOut, branchOut, ALUOpOut, opCodeOut, readData1Out, readData2Out,
    output signExtendOut, rtOut, rdOut
  );

endinterface

// File: rtl/pipe_field.sv
// Parameterized-width enable register with synchronous active-low clear (clear wins over enable).
module pipe_field #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next state: load on enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      q_q <= CLR_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_id_ex.sv
// ID/EX pipeline register: captures decode results while hit=1, holds on stall.
// Optional bubble insertion through the flush port when REG_ID_EX_FLUSH_EN is defined.
module reg_id_ex
  import mips_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  reg_id_ex_if.slave bus
);

  ctrl_t ctrl_in;
  ctrl_t ctrl_out;
  logic  ctrl_clr_n;

  assign ctrl_in = {bus.regDst, bus.ALUSrc, bus.memtoReg, bus.regWrite, bus.memRead,
                    bus.memWrite, bus.branch, bus.ALUOp, bus.opCode};

  // A flush squashes only the control bundle; data follows hit as usual.
`ifdef REG_ID_EX_FLUSH_EN
  assign ctrl_clr_n = rst_n & ~bus.flush;
`else
  assign ctrl_clr_n = rst_n;
`endif

  pipe_field #(.W($bits(ctrl_t)), .CLR_VAL(CTRL_NOP)) u_ctrl (
    .clk(clk), .clr_n_i(ctrl_clr_n), .en_i(bus.hit), .d_i(ctrl_in), .q_o(ctrl_out)
  );

  pipe_field #(.W(DATA_W)) u_nextinst (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.nextinst), .q_o(bus.nextinstOut)
  );

  pipe_field #(.W(DATA_W)) u_read_data1 (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.readData1), .q_o(bus.readData1Out)
  );

  pipe_field #(.W(DATA_W)) u_read_data2 (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.readData2), .q_o(bus.readData2Out)
  );

  pipe_field #(.W(DATA_W)) u_sign_extend (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.signExtend), .q_o(bus.signExtendOut)
  );

  pipe_field #(.W(REG_W)) u_rt (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.rt), .q_o(bus.rtOut)
  );

  pipe_field #(.W(REG_W)) u_rd (
    .clk(clk), .clr_n_i(rst_n), .en_i(bus.hit), .d_i(bus.rd), .q_o(bus.rdOut)
  );

  assign bus.regDstOut   = ctrl_out.regDst;
  assign bus.ALUSrcOut   = ctrl_out.ALUSrc;
  assign bus.memtoRegOut = ctrl_out.memtoReg;
  assign bus.regWriteOut = ctrl_out.regWrite;
  assign bus.memReadOut  = ctrl_out.memRead;
  assign bus.memWriteOut = ctrl_out.memWrite;
  assign bus.branchOut   = ctrl_out.branch;
  assign bus.ALUOpOut    = ctrl_out.ALUOp;
  assign bus.opCodeOut   = ctrl_out.opCode;

endmodule

// File: tb/tb_reg_id_ex.sv
// Self-checking bench for reg_id_ex: directed cases plus randomized traffic against a field-level model.
module tb_reg_id_ex;

  typedef struct packed {
    logic [15:0] nextinst;
    logic [6:0]  ctl_bits;   // regDst, ALUSrc, memtoReg, regWrite, memRead, memWrite, branch
    logic [1:0]  alu_op;
    logic [2:0]  op_code;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] sext;
    logic [2:0]  rt;
    logic [2:0]  rd;
  } fields_t;

  logic    clk;
  logic    rst_n;
  fields_t model;
  int      n_checks;
  int      n_fails;

  reg_id_ex_if bus ();

  reg_id_ex dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input fields_t f, input logic hit, input logic flush);
    {bus.regDst, bus.ALUSrc, bus.memtoReg, bus.regWrite, bus.memRead, bus.memWrite, bus.branch} = f.ctl_bits;
    bus.nextinst   = f.nextinst;
    bus.ALUOp      = f.alu_op;
    bus.opCode     = f.op_code;
    bus.readData1  = f.rd1;
    bus.readData2  = f.rd2;
    bus.signExtend = f.sext;
    bus.rt         = f.rt;
    bus.rd         = f.rd;
    bus.hit        = hit;
`ifdef REG_ID_EX_FLUSH_EN
    bus.flush      = flush;
`else
    if (flush) $display("note: flush requested but not compiled in");
`endif
  endtask

  // Reference: reset clears everything; flush zeroes control; hit loads whatever it is allowed to.
  function automatic fields_t next_model(input fields_t cur, input fields_t in, input logic rst,
                                         input logic hit, input logic flush);
    fields_t r;
    r = cur;
    if (!rst) return '0;
    if (hit) begin
      r.nextinst = in.nextinst;
      r.rd1 = in.rd1; r.rd2 = in.rd2; r.sext = in.sext; r.rt = in.rt; r.rd = in.rd;
      r.ctl_bits = in.ctl_bits; r.alu_op = in.alu_op; r.op_code = in.op_code;
    end
    if (flush) begin
      r.ctl_bits = 7'd0; r.alu_op = 2'd0; r.op_code = 3'd0;
    end
    return r;
  endfunction

  // One clock: drive at negedge, update model, check 1 time unit after the edge.
  task automatic step(input string tag, input fields_t in, input logic rst, input logic hit,
                      input logic flush);
    @(negedge clk);
    drive(in, hit, flush);
    rst_n = rst;
    model = next_model(model, in, rst, hit, flush);
    @(posedge clk);
    #1;
    check_eq({tag, ".nextinst"}, {16'd0, bus.nextinstOut}, {16'd0, model.nextinst});
    check_eq({tag, ".ctrl"},
             {20'd0, bus.regDstOut, bus.ALUSrcOut, bus.memtoRegOut, bus.regWriteOut, bus.memReadOut,
              bus.memWriteOut, bus.branchOut, bus.ALUOpOut, bus.opCodeOut},
             {20'd0, model.ctl_bits, model.alu_op, model.op_code});
    check_eq({tag, ".rd1_rd2"}, {bus.readData1Out, bus.readData2Out}, {model.rd1, model.rd2});
    check_eq({tag, ".sext_rt_rd"}, {10'd0, bus.signExtendOut, bus.rtOut, bus.rdOut},
             {10'd0, model.sext, model.rt, model.rd});
  endtask

  fields_t f;
  logic    flush_en;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    model    = '0;
`ifdef REG_ID_EX_FLUSH_EN
    flush_en = 1'b1;
`else
    flush_en = 1'b0;
`endif

    // Reset with all inputs nonzero
    f = '1;
    f.nextinst = 16'h00FF;
    f.op_code  = 3'b111;
    step("reset", f, 1'b0, 1'b1, 1'b0);
    check_eq("reset.opcode_zero", {29'd0, bus.opCodeOut}, 32'd0);

    // Load
    f = '0;
    f.nextinst = 16'd2;
    f.ctl_bits = 7'b1000000;
    f.op_code  = 3'b111;
    step("load", f, 1'b1, 1'b1, 1'b0);
    check_eq("load.nextinst_const", {16'd0, bus.nextinstOut}, 32'd2);
    check_eq("load.regdst_const", {31'd0, bus.regDstOut}, 32'd1);

    // Stall holds the earlier value, then release loads current inputs
    f = '0;
    f.rd1 = 16'h1234;
    step("stall_pre", f, 1'b1, 1'b1, 1'b0);
    f.rd1 = 16'hBEEF;
    for (int i = 0; i < 5; i++) step("stall", f, 1'b1, 1'b0, 1'b0);
    check_eq("stall.rd1_const", {16'd0, bus.readData1Out}, 32'h1234);

    // Hit pulse between edges must not load
    @(negedge clk);
    bus.hit = 1'b1;
    #1 bus.hit = 1'b0;
    @(posedge clk);
    #1;
    check_eq("glitch.rd1_const", {16'd0, bus.readData1Out}, 32'h1234);

    step("release", f, 1'b1, 1'b1, 1'b0);
    check_eq("release.rd1_const", {16'd0, bus.readData1Out}, 32'hBEEF);

    // Full-width patterns
    f = '0;
    f.rd2 = 16'hFFFF; f.sext = 16'h8000; f.rt = 3'b101; f.rd = 3'b010; f.alu_op = 2'b11;
    step("fullwidth", f, 1'b1, 1'b1, 1'b0);

    // Reset beats hit, and also clears mid-stall
    f = '1;
    step("rst_prio", f, 1'b0, 1'b1, 1'b0);
    step("reload", f, 1'b1, 1'b1, 1'b0);
    step("rst_stall", f, 1'b0, 1'b0, 1'b0);
    step("post_rst", f, 1'b1, 1'b1, 1'b0);

    // Flush squashes control only
    if (flush_en) begin
      f = '0;
      f.ctl_bits = 7'b0001000;
      f.rd1 = 16'h0042;
      step("flush", f, 1'b1, 1'b1, 1'b1);
      check_eq("flush.regwrite_const", {31'd0, bus.regWriteOut}, 32'd0);
      check_eq("flush.rd1_const", {16'd0, bus.readData1Out}, 32'h0042);
      f.rd1 = 16'h5555;
      step("flush_stall", f, 1'b1, 1'b0, 1'b1);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      f = fields_t'({$urandom, $urandom, $urandom, $urandom});
      step("rand", f, ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           flush_en & ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
